// File: rtl/seven_segment_mux_counter.sv
// rtl/seven_segment_mux_counter.sv - multi-digit BCD/hex up/down counter with muxed 7-segment scan
module seven_segment_mux_counter #(
    parameter int DIGITS     = 4,
    parameter int TICK_WIDTH = 24,
    parameter int SCAN_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  count_en,
    input  logic                  up_down,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic                  clear,
    input  logic [TICK_WIDTH-1:0] tick_compare,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   count_value,
    output logic                  tick,
    output logic                  overflow
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [TICK_WIDTH-1:0] presc;
    logic [SCAN_WIDTH-1:0] scan_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [4*DIGITS-1:0]   next_value;
    logic                  carry;
    logic [3:0]            d;
    logic [3:0]            nd;
    logic [3:0]            max_d;
    logic                  run;
    logic [DIGITS-1:0]     lz_blank;
    logic [3:0]            cur_digit;
    logic                  cur_blank;

    // Values above 9 in decimal mode are leftovers from hex mode and display blank.
    function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        g = 7'b0000000;
        case (v)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            4'hF: g = 7'b1110001;
            default: g = 7'b0000000;
        endcase
        if (!hex && v > 4'd9) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (clear || tick_compare == '0) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == tick_compare) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + TICK_WIDTH'(1);
            tick  <= 1'b0;
        end
    end

    // Ripple carry/borrow across the digits; whatever survives the top digit is the wrap.
    always_comb begin
        next_value = count_value;
        carry      = 1'b1;
        d          = 4'd0;
        nd         = 4'd0;
        max_d      = hex_mode ? 4'hF : 4'd9;
        for (int i = 0; i < DIGITS; i++) begin
            d  = count_value[4*i +: 4];
            nd = d;
            if (carry) begin
                if (up_down) begin
                    if (d >= max_d) begin
                        nd = 4'd0;
                    end else begin
                        nd    = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        nd = max_d;
                    end else if (!hex_mode && d > 4'd9) begin
                        nd    = 4'd8;
                        carry = 1'b0;
                    end else begin
                        nd    = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            next_value[4*i +: 4] = nd;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count_value <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            count_value <= '0;
            overflow    <= 1'b0;
        end else if (tick && count_en) begin
            count_value <= next_value;
            overflow    <= carry;
        end else begin
            overflow    <= 1'b0;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        run      = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run         = run && (count_value[4*i +: 4] == 4'd0);
            lz_blank[i] = run && (i != 0);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit = count_value[4*i +: 4];
                cur_blank = lz_blank[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= '0;
            segments  <= 7'b0000000;
        end else begin
            scan_cnt <= scan_cnt + SCAN_WIDTH'(1);
            if (&scan_cnt) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
            end
            digit_sel <= DIGITS'(1) << scan_idx;
            segments  <= (blank_lz && cur_blank) ? 7'b0000000 : glyph(cur_digit, hex_mode);
        end
    end

endmodule
